// File: rtl/time_set_controller.sv
// Manual time-set front end: synchronizes and debounces three buttons, steps a
// field selector through the settable fields, and emits up/down pulses with auto-repeat.
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int NUM_FIELDS      = 6,
    localparam int SEL_W          = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_mode,
    input  logic                  btn_up,
    input  logic                  btn_down,
    output logic                  manual_set,
    output logic [SEL_W-1:0]      field_sel,
    output logic [NUM_FIELDS-1:0] field_en,
    output logic                  up,
    output logic                  down
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX) + 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0]  DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0]  PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_FIELDS - 1);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    // Button index: 0 = mode, 1 = up, 2 = down.
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      deb;
    logic [2:0]      deb_q;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    assign raw   = {btn_down, btn_up, btn_mode};
    assign press = deb & ~deb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    state_t          state, state_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [NUM_FIELDS-1:0] en_nxt;
    logic            arm_up, arm_up_nxt;
    logic            arm_dn, arm_dn_nxt;
    logic            rpt_first, rpt_first_nxt;
    logic [RP_W-1:0] rpt_cnt, rpt_cnt_nxt;
    logic            rpt_due;
    logic            up_nxt;
    logic            dn_nxt;

    always_comb begin
        state_nxt     = state;
        sel_nxt       = field_sel;
        arm_up_nxt    = arm_up;
        arm_dn_nxt    = arm_dn;
        rpt_first_nxt = rpt_first;
        rpt_cnt_nxt   = rpt_cnt;
        up_nxt        = 1'b0;
        dn_nxt        = 1'b0;
        rpt_due       = rpt_first ? (rpt_cnt >= DELAY_LAST) : (rpt_cnt >= PERIOD_LAST);

        if (press[0]) begin
            // A mode press always disarms, so no pulse can coincide with a field change.
            arm_up_nxt  = 1'b0;
            arm_dn_nxt  = 1'b0;
            rpt_cnt_nxt = '0;
            if (state == ST_RUN) begin
                state_nxt = ST_SET;
                sel_nxt   = '0;
            end else if (field_sel == SEL_LAST) begin
                state_nxt = ST_RUN;
                sel_nxt   = '0;
            end else begin
                sel_nxt = field_sel + SEL_W'(1);
            end
        end else if (state == ST_RUN) begin
            arm_up_nxt  = 1'b0;
            arm_dn_nxt  = 1'b0;
            rpt_cnt_nxt = '0;
        end else if (arm_up) begin
            if (!deb[1] || deb[2]) begin
                arm_up_nxt  = 1'b0;
                rpt_cnt_nxt = '0;
            end else if (rpt_due) begin
                up_nxt        = 1'b1;
                rpt_cnt_nxt   = '0;
                rpt_first_nxt = 1'b0;
            end else begin
                rpt_cnt_nxt = rpt_cnt + RP_W'(1);
            end
        end else if (arm_dn) begin
            if (!deb[2] || deb[1]) begin
                arm_dn_nxt  = 1'b0;
                rpt_cnt_nxt = '0;
            end else if (rpt_due) begin
                dn_nxt        = 1'b1;
                rpt_cnt_nxt   = '0;
                rpt_first_nxt = 1'b0;
            end else begin
                rpt_cnt_nxt = rpt_cnt + RP_W'(1);
            end
        end else if (press[1] && !deb[2]) begin
            arm_up_nxt    = 1'b1;
            up_nxt        = 1'b1;
            rpt_cnt_nxt   = '0;
            rpt_first_nxt = 1'b1;
        end else if (press[2] && !deb[1]) begin
            arm_dn_nxt    = 1'b1;
            dn_nxt        = 1'b1;
            rpt_cnt_nxt   = '0;
            rpt_first_nxt = 1'b1;
        end

        en_nxt = (state_nxt == ST_SET) ? (NUM_FIELDS'(1) << sel_nxt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            field_sel  <= '0;
            field_en   <= '0;
            manual_set <= 1'b0;
            arm_up     <= 1'b0;
            arm_dn     <= 1'b0;
            rpt_first  <= 1'b0;
            rpt_cnt    <= '0;
            up         <= 1'b0;
            down       <= 1'b0;
        end else begin
            state      <= state_nxt;
            field_sel  <= sel_nxt;
            field_en   <= en_nxt;
            manual_set <= (state_nxt == ST_SET);
            arm_up     <= arm_up_nxt;
            arm_dn     <= arm_dn_nxt;
            rpt_first  <= rpt_first_nxt;
            rpt_cnt    <= rpt_cnt_nxt;
            up         <= up_nxt;
            down       <= dn_nxt;
        end
    end

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed scenarios plus random button activity,
// checked every cycle against an event-level reference model.
module tb_time_set_controller;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int NF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       manual_set;
    logic [2:0] field_sel;
    logic [5:0] field_en;
    logic       up;
    logic       down;

    time_set_controller #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .NUM_FIELDS     (NF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .manual_set(manual_set),
        .field_sel (field_sel),
        .field_en  (field_en),
        .up        (up),
        .down      (down)
    );

    always #5 clk = ~clk;

    // Reference model: debounced level flips after D consecutive synchronized samples
    // disagree with it; pulses are scheduled by absolute cycle number.
    logic [15:0] hist [3];
    logic [2:0]  mdeb = '0;
    logic [2:0]  mdeb_prev = '0;
    bit          m_set = 0;
    int          m_sel = 0;
    int          m_arm = 0;   // 0 none, 1 up, 2 down
    int          m_next = 0;
    int          mcyc = 0;
    logic        exp_ms = 0;
    logic [2:0]  exp_sel = '0;
    logic [5:0]  exp_en = '0;
    logic        exp_up = 0;
    logic        exp_dn = 0;

    always @(posedge clk or posedge rst) begin : model
        logic [2:0] r;
        logic       mode_p, up_p, dn_p, all_diff;
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            mdeb = '0; mdeb_prev = '0;
            m_set = 0; m_sel = 0; m_arm = 0; m_next = 0;
            exp_ms = 0; exp_sel = '0; exp_en = '0; exp_up = 0; exp_dn = 0;
        end else begin
            r = {btn_down, btn_up, btn_mode};
            mcyc++;
            mode_p = mdeb[0] && !mdeb_prev[0];
            up_p   = mdeb[1] && !mdeb_prev[1];
            dn_p   = mdeb[2] && !mdeb_prev[2];
            exp_up = 0;
            exp_dn = 0;
            if (mode_p) begin
                m_arm = 0;
                if (!m_set) begin m_set = 1; m_sel = 0; end
                else if (m_sel == NF - 1) begin m_set = 0; m_sel = 0; end
                else m_sel = m_sel + 1;
            end else if (!m_set) begin
                m_arm = 0;
            end else if (m_arm == 1) begin
                if (!mdeb[1] || mdeb[2]) m_arm = 0;
                else if (mcyc == m_next) begin exp_up = 1; m_next = mcyc + RP; end
            end else if (m_arm == 2) begin
                if (!mdeb[2] || mdeb[1]) m_arm = 0;
                else if (mcyc == m_next) begin exp_dn = 1; m_next = mcyc + RP; end
            end else if (up_p && !mdeb[2]) begin
                m_arm = 1; exp_up = 1; m_next = mcyc + RD;
            end else if (dn_p && !mdeb[1]) begin
                m_arm = 2; exp_dn = 1; m_next = mcyc + RD;
            end
            exp_ms  = m_set;
            exp_sel = 3'(m_sel);
            exp_en  = m_set ? (6'd1 << m_sel) : 6'd0;
            mdeb_prev = mdeb;
            for (int i = 0; i < 3; i++) begin
                hist[i] = {hist[i][14:0], r[i]};
                all_diff = 1;
                for (int j = 2; j <= D + 1; j++) if (hist[i][j] == mdeb[i]) all_diff = 0;
                if (all_diff) mdeb[i] = ~mdeb[i];
            end
        end
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_q [$];
    logic [31:0] up_times [$];
    logic [31:0] dn_times [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("manual_set", 32'(manual_set), 32'(exp_ms));
        check("field_sel",  32'(field_sel),  32'(exp_sel));
        check("field_en",   32'(field_en),   32'(exp_en));
        check("up",         32'(up),         32'(exp_up));
        check("down",       32'(down),       32'(exp_dn));
        if (up)   up_times.push_back(32'(cyc));
        if (down) dn_times.push_back(32'(cyc));
    endtask

    task automatic check_queue(input string tag, input bit use_up);
        logic [31:0] got;
        check({tag, "_count"}, use_up ? 32'(up_times.size()) : 32'(dn_times.size()),
              32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (use_up) got = (i < up_times.size()) ? up_times[i] : '1;
            else        got = (i < dn_times.size()) ? dn_times[i] : '1;
            check({tag, "_time"}, got, exp_q[i]);
        end
    endtask

    task automatic clear_pulses();
        up_times.delete();
        dn_times.delete();
        exp_q.delete();
    endtask

    task automatic press_mode();
        btn_mode = 1;
        repeat (10) tick();
        btn_mode = 0;
        repeat (10) tick();
    endtask

    initial begin
        int          c0;
        logic [5:0]  e_en;

        // Reset and idle
        repeat (3) tick();
        check("reset_manual_set", 32'(manual_set), 0);
        check("reset_field_en",   32'(field_en),   0);
        rst = 0;
        repeat (3) tick();

        // Up held in RUN produces nothing
        clear_pulses();
        btn_up = 1;
        repeat (50) tick();
        btn_up = 0;
        repeat (10) tick();
        check_queue("run_up", 1);
        check("run_manual_set", 32'(manual_set), 0);

        // Field cycling with exact press latency on the first press
        btn_mode = 1;
        repeat (6) tick();
        check("mode_edge6_ms", 32'(manual_set), 0);
        tick();
        check("mode_edge7_ms",  32'(manual_set), 1);
        check("mode_edge7_sel", 32'(field_sel),  0);
        check("mode_edge7_en",  32'(field_en),   32'(6'b000001));
        repeat (3) tick();
        btn_mode = 0;
        repeat (10) tick();
        for (int f = 1; f < NF; f++) begin
            press_mode();
            e_en = 6'd1 << f;
            check("cycle_sel", 32'(field_sel), 32'(f));
            check("cycle_en",  32'(field_en),  32'(e_en));
            check("cycle_ms",  32'(manual_set), 1);
        end
        press_mode();
        check("wrap_ms",  32'(manual_set), 0);
        check("wrap_sel", 32'(field_sel),  0);
        check("wrap_en",  32'(field_en),   0);
        press_mode();

        // Bounce rejection: single pulse 7 edges after last rising transition
        clear_pulses();
        c0 = 0;
        for (int i = 0; i < 10; i++) begin
            btn_up = ((i / 2) % 2 == 0);
            if (i == 8) c0 = cyc;
            tick();
        end
        repeat (10) tick();
        btn_up = 0;
        repeat (20) tick();
        exp_q.push_back(32'(c0 + 7));
        check_queue("bounce_up", 1);
        exp_q.delete();
        check_queue("bounce_dn", 0);

        // Auto-repeat on down; release disarms at release edge D+3
        clear_pulses();
        c0 = cyc;
        btn_down = 1;
        repeat (60) tick();
        btn_down = 0;
        repeat (30) tick();
        exp_q.push_back(32'(c0 + 7));
        for (int t = c0 + 7 + RD; t < c0 + 60 + D + 3; t += RP) exp_q.push_back(32'(t));
        check_queue("repeat_dn", 0);
        exp_q.delete();
        check_queue("repeat_up", 1);

        // Conflict: down going high stops up repeats; stale hold stays silent
        clear_pulses();
        c0 = cyc;
        btn_up = 1;
        repeat (30) tick();
        btn_down = 1;
        repeat (20) tick();
        btn_up = 0;
        repeat (20) tick();
        btn_down = 0;
        repeat (15) tick();
        exp_q.push_back(32'(c0 + 7));
        exp_q.push_back(32'(c0 + 7 + RD));
        exp_q.push_back(32'(c0 + 7 + RD + RP));
        check_queue("conflict_up", 1);
        exp_q.delete();
        check_queue("conflict_dn", 0);
        clear_pulses();
        c0 = cyc;
        btn_down = 1;
        repeat (10) tick();
        btn_down = 0;
        repeat (15) tick();
        exp_q.push_back(32'(c0 + 7));
        check_queue("repress_dn", 0);

        // Reset in the middle of an up auto-repeat
        clear_pulses();
        btn_up = 1;
        repeat (30) tick();
        check("pre_reset_up_count", 32'(up_times.size()), 2);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("async_rst_up",  32'(up),         0);
        check("async_rst_ms",  32'(manual_set), 0);
        check("async_rst_en",  32'(field_en),   0);
        check("async_rst_sel", 32'(field_sel),  0);
        @(negedge clk);
        repeat (3) tick();
        rst = 0;
        clear_pulses();
        repeat (40) tick();
        check_queue("post_reset_up", 1);
        check("post_reset_ms", 32'(manual_set), 0);
        btn_up = 0;
        repeat (10) tick();

        // Random button activity against the model
        repeat (60) begin
            btn_mode = ($urandom_range(0, 3) == 0);
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 40)) tick();
        end
        btn_mode = 0;
        btn_up   = 0;
        btn_down = 0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
